// File: rtl/tlc_sequencer.sv
// rtl/tlc_sequencer.sv - two-road traffic light Moore sequencer driving an external phase timer
// Optional pedestrian walk phase enabled by defining TLC_PED_EN.
module tlc_sequencer #(
    parameter int MAIN_MIN = 60,
    parameter int SIDE_T   = 30,
    parameter int YEL_T    = 5,
    parameter int RED_T    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic [6:0] tmr_count,
`ifdef TLC_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic       tmr_clear,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] state
);

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_MAIN_GRN = 3'd1;
    localparam logic [2:0] S_MAIN_YEL = 3'd2;
    localparam logic [2:0] S_RED_A    = 3'd3;
    localparam logic [2:0] S_SIDE_GRN = 3'd4;
    localparam logic [2:0] S_SIDE_YEL = 3'd5;
    localparam logic [2:0] S_RED_B    = 3'd6;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    localparam logic [6:0] MAIN_LAST = 7'(MAIN_MIN - 1);
    localparam logic [6:0] SIDE_LAST = 7'(SIDE_T - 1);
    localparam logic [6:0] YEL_LAST  = 7'(YEL_T - 1);
    localparam logic [6:0] RED_LAST  = 7'(RED_T - 1);

    logic [2:0] next_state;
    logic       req_pend;
    logic       min_done;
    logic       serve_req;
    logic       main_hit;
    logic       enter_side;

`ifdef TLC_PED_EN
    logic ped_pend;
    assign serve_req = req_pend | ped_pend;
`else
    assign serve_req = req_pend;
`endif

    assign main_hit   = (tmr_count == MAIN_LAST);
    assign enter_side = (next_state == S_SIDE_GRN) && (state != S_SIDE_GRN);

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:     next_state = S_MAIN_GRN;
            // min_done keeps the minimum satisfied after the timer wraps
            S_MAIN_GRN: if (serve_req && (min_done || main_hit)) next_state = S_MAIN_YEL;
            S_MAIN_YEL: if (tmr_count == YEL_LAST)  next_state = S_RED_A;
            S_RED_A:    if (tmr_count == RED_LAST)  next_state = S_SIDE_GRN;
            S_SIDE_GRN: if (tmr_count == SIDE_LAST) next_state = S_SIDE_YEL;
            S_SIDE_YEL: if (tmr_count == YEL_LAST)  next_state = S_RED_B;
            S_RED_B:    if (tmr_count == RED_LAST)  next_state = S_MAIN_GRN;
            default:    next_state = S_INIT;
        endcase
    end

    assign tmr_clear = reset | (next_state != state);

    always_comb begin
        main_light = L_RED;
        side_light = L_RED;
        case (state)
            S_MAIN_GRN: main_light = L_GRN;
            S_MAIN_YEL: main_light = L_YEL;
            S_SIDE_GRN: side_light = L_GRN;
            S_SIDE_YEL: side_light = L_YEL;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_INIT;
            req_pend <= 1'b0;
            min_done <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_MAIN_GRN && next_state == S_MAIN_GRN)
                min_done <= min_done | main_hit;
            else
                min_done <= 1'b0;
            // clear on entry to side green wins over a simultaneous request
            if (enter_side)
                req_pend <= 1'b0;
            else if (side_req && state != S_SIDE_GRN)
                req_pend <= 1'b1;
        end
    end

`ifdef TLC_PED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pend <= 1'b0;
            walk     <= 1'b0;
        end else begin
            if (enter_side)
                ped_pend <= 1'b0;
            else if (ped_req)
                ped_pend <= 1'b1;
            if (enter_side)
                walk <= ped_pend;
            else if (next_state != S_SIDE_GRN)
                walk <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tlc_sequencer.sv
// tb/tb_tlc_sequencer.sv - directed-vector bench for tlc_sequencer with a bench-side phase timer
module tb_tlc_sequencer;

    logic       clk;
    logic       reset;
    logic       side_req;
    logic [6:0] tmr_count;
    logic       tmr_clear;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [2:0] state;
`ifdef TLC_PED_EN
    logic       ped_req;
    logic       walk;
`endif

    int total;
    int bad;

    tlc_sequencer #(
        .MAIN_MIN(4),
        .SIDE_T  (3),
        .YEL_T   (2),
        .RED_T   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .side_req  (side_req),
        .tmr_count (tmr_count),
`ifdef TLC_PED_EN
        .ped_req   (ped_req),
        .walk      (walk),
`endif
        .tmr_clear (tmr_clear),
        .main_light(main_light),
        .side_light(side_light),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (tmr_clear)
            tmr_count <= 7'd0;
        else
            tmr_count <= tmr_count + 7'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [2:0] exp_main(input int s);
        case (s)
            1: return 3'b001;
            2: return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input int s);
        case (s)
            4: return 3'b001;
            5: return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    int seq_a[14];
    int seq_b[7];
    int seq_c[6];

    task automatic reset_and_start();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_main", 32'(main_light), 32'h4);
        chk("rst_side", 32'(side_light), 32'h4);
        chk("rst_clear", 32'(tmr_clear), 32'd1);
        reset = 1'b0;
        #1;
        chk("init_state", 32'(state), 32'd0);
        chk("init_clear", 32'(tmr_clear), 32'd1);
        tick();
        chk("start_state", 32'(state), 32'd1);
        chk("start_main", 32'(main_light), 32'h1);
        chk("start_tmr", 32'(tmr_count), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        side_req = 1'b0;
`ifdef TLC_PED_EN
        ped_req  = 1'b0;
`endif
        seq_a = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 5, 5, 6, 1};
        seq_b = '{5, 6, 1, 1, 1, 1, 2};
        seq_c = '{2, 3, 4, 4, 4, 5};

        reset_and_start();

        // full cycle with the request held from the first green cycle
        side_req = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) tick();
            chk($sformatf("cyc_state[%0d]", i), 32'(state), 32'(seq_a[i]));
            chk($sformatf("cyc_main[%0d]", i), 32'(main_light), 32'(exp_main(seq_a[i])));
            chk($sformatf("cyc_side[%0d]", i), 32'(side_light), 32'(exp_side(seq_a[i])));
            if (i < 13)
                chk($sformatf("cyc_clear[%0d]", i), 32'(tmr_clear), 32'(seq_a[i+1] != seq_a[i]));
            if (seq_a[i] == 4) side_req = 1'b0;
        end

        // no request: green holds through the timer wrap
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("hold_state", 32'(state), 32'd1);
        end
        chk("hold_tmr_wrap", 32'(tmr_count), 32'd44);

        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        chk("pulse_state", 32'(state), 32'd1);
        chk("pulse_clear", 32'(tmr_clear), 32'd1);
        tick();
        chk("pulse_yel_state", 32'(state), 32'd2);
        chk("pulse_yel_main", 32'(main_light), 32'h2);
        chk("pulse_yel_tmr", 32'(tmr_count), 32'd0);

        // request arriving in side yellow is served after a full minimum green
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("late_pre[%0d]", i), 32'(state), 32'(seq_c[i]));
        end
        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            chk($sformatf("late_seq[%0d]", i), 32'(state), 32'(seq_b[i]));
        end

        // asynchronous reset in side green
        tick();
        chk("pre_rst_s3", 32'(state), 32'd2);
        tick();
        tick();
        tick();
        chk("pre_rst_s4", 32'(state), 32'd4);
        reset = 1'b1;
        #1;
        chk("async_main", 32'(main_light), 32'h4);
        chk("async_side", 32'(side_light), 32'h4);
        chk("async_state", 32'(state), 32'd0);
        reset_and_start();

`ifdef TLC_PED_EN
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            chk($sformatf("ped_walk[%0d]", i), 32'(walk), 32'(state == 3'd4));
        end
        chk("ped_end_state", 32'(state), 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/tlc_sequencer.md
TLC_SEQUENCER -- requirements
Module: tlc_sequencer

Interface
REQ-001 SHALL have parameter MAIN_MIN, default 60: minimum main-road green, in cycles, range 1..127.
REQ-002 SHALL have parameter SIDE_T, default 30: side-road green, in cycles, range 1..127.
REQ-003 SHALL have parameter YEL_T, default 5: yellow duration for either road, in cycles, range 1..127.
REQ-004 SHALL have parameter RED_T, default 2: all-red clearance, in cycles, range 1..127.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port side_req, input, 1 bit: side-road vehicle sensor, level or pulse.
REQ-008 SHALL have port tmr_count, input, 7 bits: current value of the external phase timer.
REQ-009 SHALL have port tmr_clear, output, 1 bit: synchronous clear to the external phase timer.
REQ-010 SHALL have port main_light, output, 3 bits: one-hot {red,yellow,green} for the main road.
REQ-011 SHALL have port side_light, output, 3 bits: one-hot {red,yellow,green} for the side road.
REQ-012 SHALL have port state, output, 3 bits: current FSM state code, for debug.

Function
REQ-013 SHALL implement the Moore FSM INIT(0) -> MAIN_GRN(1) -> MAIN_YEL(2) -> RED_A(3) -> SIDE_GRN(4) -> SIDE_YEL(5) -> RED_B(6) -> MAIN_GRN.
REQ-014 Light decode SHALL be as follows: MAIN_GRN = main 001, side 100; MAIN_YEL = main 010, side 100; SIDE_GRN = main 100, side 001; SIDE_YEL = main 100, side 010; INIT, RED_A and RED_B = both 100.
REQ-015 INIT SHALL last exactly 1 cycle, with tmr_clear=1, and then go to MAIN_GRN.
REQ-016 A timed state of duration D SHALL leave when tmr_count==D-1, so that it occupies exactly D cycles; D is YEL_T, RED_T or SIDE_T as applicable.
REQ-017 tmr_clear SHALL be combinational and equal to 1 exactly in cycles where the next state differs from the current state, so the timer reads 0 on the first cycle of every state.
REQ-018 A registered flag min_done SHALL be set in MAIN_GRN when tmr_count==MAIN_MIN-1 and SHALL be cleared on leaving MAIN_GRN.
REQ-019 MAIN_GRN SHALL leave only when req_pend=1 and (min_done=1 or tmr_count==MAIN_MIN-1).
REQ-020 Because of REQ-018, main green SHALL hold indefinitely with no request, even after tmr_count wraps from 127 to 0.
REQ-021 A registered flag req_pend SHALL be set by side_req=1 in any state except SIDE_GRN.
REQ-022 req_pend SHALL be cleared on the transition into SIDE_GRN; if set and clear occur in the same cycle, clear SHALL win.
REQ-023 A request arriving in SIDE_YEL or RED_B SHALL stay pending and be served after the next MAIN_MIN.
REQ-024 Unused state codes SHALL recover to INIT on the next cycle.

Reset
REQ-025 While reset=1 the block SHALL hold: state=INIT, main_light=100, side_light=100, tmr_clear=1, req_pend=0, min_done=0.
REQ-026 Reset asserted mid-cycle SHALL force both roads red immediately, without waiting for a clock edge.

Configuration
REQ-027 With macro TLC_PED_EN defined, the block SHALL add input ped_req (1 bit) and output walk (1 bit, reset 0).
REQ-028 With TLC_PED_EN, ped_req SHALL set a latched ped_pend flag that ends MAIN_GRN exactly as req_pend does.
REQ-029 With TLC_PED_EN, walk=1 SHALL be driven throughout a SIDE_GRN entered with ped_pend=1, and ped_pend SHALL be cleared on that entry.
REQ-030 Without TLC_PED_EN, the ped_req and walk ports SHALL be absent and behaviour SHALL be as REQ-013..REQ-024.

Verification (MAIN_MIN=4, SIDE_T=3, YEL_T=2, RED_T=1; bench drives tmr_count from a 7-bit counter cleared by tmr_clear)
REQ-031 Release reset -> state=0 with tmr_clear=1 for 1 cycle, then state=1, main_light=001, tmr_count=0.
REQ-032 side_req held from the first MAIN_GRN cycle -> state sequence 1x4, 2x2, 3x1, 4x3, 5x2, 6x1, then 1; tmr_clear high on each last cycle.
REQ-033 No side_req for 300 cycles -> stays in state 1 through the tmr_count wrap; then a 1-cycle side_req pulse -> state=2 on the next cycle.
REQ-034 side_req pulse during state 5 -> after return to state 1, exactly 4 green cycles, then state 2.
REQ-035 Assert reset during state 4 -> main_light=side_light=100 before the next edge; after release, the INIT sequence as in REQ-031.
REQ-036 With TLC_PED_EN, a ped_req pulse in state 1 -> walk=1 for all 3 cycles of state 4 and 0 elsewhere.
